lane_judge_arbiter: RTL and testbench
=====================================

# lane_judge_arbiter

Collects per-lane judgement results from the lane button judges (red, blue, green, yellow) and serialises them onto the single score-update port of the score block. Each judge's one-cycle result is latched into a per-lane pending slot. A round-robin arbiter then issues one event at a time over a valid/ready handshake. An optional combo counter tracks consecutive non-miss events.

## Interface
Parameters:
- LANES, default 4: number of lane judges; supported range 2..8.
- COMBO_W, default 8: width of the combo counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- lane_req  in  LANES  one-cycle strobe per lane: the judge has produced a result this cycle.
- lane_grade  in  2*LANES  grade for lane i at bits [2i+1:2i]. Encoding: 11 perfect, 10 late, 01 early, 00 miss/none.
- out_valid  out  1  event available to the score block.
- out_ready  in  1  score block accepts the event this cycle.
- out_lane  out  clog2(LANES)  lane index of the current event.
- out_grade  out  2  grade of the current event.
- combo  out  COMBO_W  consecutive accepted non-miss events.
- overrun  out  1  sticky flag: a pending result was overwritten before it was served.

## Operation
- Per-lane pending storage: pend[i] (1 bit) plus pgrade[i] (2 bits).
  - On lane_req[i], set pend[i] and load pgrade[i] from lane_grade.
  - Grade 00 is queued like any other grade; it is a miss event.
- Output stage: out_valid/out_lane/out_grade form a register. It is loadable when out_valid==0, or when out_valid && out_ready.
- Arbitration, evaluated on a loadable cycle:
  - Search pend[] starting at ptr+1, wrapping modulo LANES. The first set lane wins.
  - The winner's lane index and grade are loaded into the output stage, out_valid=1, and pend[winner] is cleared.
  - ptr becomes the winner.
  - If no lane is pending, out_valid becomes 0.
- Arbitration uses only registered pend[]. A lane_req arriving in a cycle is not eligible for grant in that same cycle.
- Set beats clear: if lane_req[i] coincides with lane i being granted, the granted (old) grade goes out and pend[i] stays set with the new grade.
- Overwrite: lane_req[i] while pend[i]==1 and lane i is not granted that cycle:
  - pgrade[i] is replaced by the new grade.
  - overrun is set to 1 and stays 1 until rst.
- Simultaneous requests on several lanes are all latched in the same cycle.
- Out-of-range LANES is not supported; there is no runtime check.

## Timing
- Reset (rst high at a clk edge) forces:
  - pend = 0, pgrade = 0.
  - out_valid = 0, out_lane = 0, out_grade = 0.
  - ptr = LANES-1, so lane 0 has first priority.
  - combo = 0, overrun = 0.
- Reset mid-operation discards all pending and in-flight events. lane_req asserted during the rst cycle is ignored.
- Latency:
  - lane_req sampled at edge k sets pend at edge k.
  - out_valid rises at edge k+1 if the output stage is loadable and the lane wins.
  - Minimum request-to-valid latency is 2 edges.
- Handshake rules:
  - While out_valid && !out_ready, out_lane and out_grade hold stable.
  - A transfer occurs on any edge with out_valid && out_ready.
  - Throughput is one event per cycle when out_ready is held high.
- Round-robin fairness: with all LANES pending and out_ready high, grants follow ptr+1, ptr+2, ... and each lane is served once per LANES transfers.

## Configuration
- Macro LANE_JUDGE_COMBO_EN.
- Defined: combo updates on each transfer (out_valid && out_ready).
  - out_grade==00 → combo=0.
  - Otherwise → combo+1, saturating at 2^COMBO_W-1.
  - rst clears combo.
- Undefined: no combo register is built and combo is tied to 0. All other behaviour is identical.

## Test plan
- Single request: rst, then lane_req=0010 with lane 1 grade=11, out_ready=1 → out_valid=1 two edges later with out_lane=1, out_grade=11. The transfer completes and out_valid=0 on the next edge.
- Round-robin: after rst, lane_req=1111 with grades 11,10,01,11 (lane0..3), out_ready=1 → lanes 0,1,2,3 emitted on 4 consecutive cycles with matching grades. A second 1111 burst is again served 0..3.
- Backpressure: hold out_ready=0 for 5 cycles with lanes 0 and 2 pending → out_lane=0 and out_grade stay constant. After out_ready=1, lane 0 transfers, then lane 2.
- Overrun: out_ready=0; lane 3 requests grade 01, then grade 11 two cycles later → overrun=1. Releasing out_ready emits exactly one lane-3 event with grade 11.
- Set-beats-clear: lane 0 pending and granted in the same cycle a new lane_req[0] (grade 10) arrives → the old grade is emitted, a second lane-0 event with grade 10 follows, and overrun stays 0.
- Combo (macro defined, COMBO_W=2): transfers with grades 11,10,01,11,00 → combo reads 1,2,3,3 (saturated), then 0. rst mid-burst → all outputs return to reset values next edge and no stale event appears.

Source files
------------

// File: rtl/lane_judge_arbiter_if.sv
// Bus between the lane judges / score block and the lane judge arbiter.
// master: the arbiter side; slave: the judges and score block side.
interface lane_judge_arbiter_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned COMBO_W = 8
);
  localparam int unsigned LaneW = $clog2(LANES);

  logic [LANES-1:0]   lane_req;
  logic [2*LANES-1:0] lane_grade;
  logic               out_valid;
  logic               out_ready;
  logic [LaneW-1:0]   out_lane;
  logic [1:0]         out_grade;
  logic [COMBO_W-1:0] combo;
  logic               overrun;

  modport master (
    input  lane_req, lane_grade, out_ready,
    output out_valid, out_lane, out_grade, combo, overrun
  );

  modport slave (
    output lane_req, lane_grade, out_ready,
    input  out_valid, out_lane, out_grade, combo, overrun
  );
endinterface

// File: rtl/lane_judge_arbiter.sv
// Latches per-lane judge results into pending slots and serialises them,
// round-robin, onto a single valid/ready score-update port.
// Optional combo counter built only when LANE_JUDGE_COMBO_EN is defined.
module lane_judge_arbiter #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned COMBO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lane_judge_arbiter_if.master  bus
);
  localparam int unsigned LaneW = $clog2(LANES);

  logic [LANES-1:0]      pend_q, pend_d;
  logic [LANES-1:0][1:0] pgrade_q, pgrade_d;
  logic                  out_valid_q, out_valid_d;
  logic [LaneW-1:0]      out_lane_q, out_lane_d;
  logic [1:0]            out_grade_q, out_grade_d;
  logic [LaneW-1:0]      ptr_q, ptr_d;
  logic                  overrun_q, overrun_d;

  logic                  loadable;
  logic                  grant_vld;
  logic [LaneW-1:0]      grant_idx;
  logic [LaneW-1:0]      cand;
  logic                  granted;

  assign loadable = !out_valid_q || bus.out_ready;
  assign granted  = loadable && grant_vld;

  // Round-robin search over registered pend[], starting just after ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= LANES; off++) begin
      cand = LaneW'((32'(ptr_q) + off) % LANES);
      if (!grant_vld && pend_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next state for pending slots, output stage, pointer and overrun flag.
  always_comb begin
    pend_d      = pend_q;
    pgrade_d    = pgrade_q;
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    out_grade_d = out_grade_q;
    ptr_d       = ptr_q;
    overrun_d   = overrun_q;

    if (loadable) begin
      if (grant_vld) begin
        out_valid_d       = 1'b1;
        out_lane_d        = grant_idx;
        out_grade_d       = pgrade_q[grant_idx];
        pend_d[grant_idx] = 1'b0;
        ptr_d             = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // New requests applied last so a set wins over the grant's clear.
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_req[i]) begin
        if (pend_q[i] && !(granted && grant_idx == LaneW'(i))) begin
          overrun_d = 1'b1;
        end
        pend_d[i]   = 1'b1;
        pgrade_d[i] = bus.lane_grade[2*i +: 2];
      end
    end
  end

  // State registers with synchronous reset; ptr resets so lane 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pgrade_q    <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_grade_q <= '0;
      ptr_q       <= LaneW'(LANES - 1);
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pgrade_q    <= pgrade_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_grade_q <= out_grade_d;
      ptr_q       <= ptr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_grade = out_grade_q;
  assign bus.overrun   = overrun_q;

`ifdef LANE_JUDGE_COMBO_EN
  logic [COMBO_W-1:0] combo_q, combo_d;

  // Combo: reset on a transferred miss, saturating increment otherwise.
  always_comb begin
    combo_d = combo_q;
    if (out_valid_q && bus.out_ready) begin
      if (out_grade_q == 2'b00) begin
        combo_d = '0;
      end else if (combo_q != {COMBO_W{1'b1}}) begin
        combo_d = combo_q + 1'b1;
      end
    end
  end

  // Combo register.
  always_ff @(posedge clk) begin
    if (rst) begin
      combo_q <= '0;
    end else begin
      combo_q <= combo_d;
    end
  end

  assign bus.combo = combo_q;
`else
  assign bus.combo = {COMBO_W{1'b0}};
`endif

endmodule

// File: tb/tb_lane_judge_arbiter.sv
// Directed self-checking bench for lane_judge_arbiter (LANES=4, COMBO_W=2).
module tb_lane_judge_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

`ifdef LANE_JUDGE_COMBO_EN
  localparam bit ComboEn = 1'b1;
`else
  localparam bit ComboEn = 1'b0;
`endif

  lane_judge_arbiter_if #(.LANES(4), .COMBO_W(2)) bus ();

  lane_judge_arbiter #(.LANES(4), .COMBO_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] l,
                         input logic [1:0] g);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({tag, ".lane"}, 32'(bus.out_lane), 32'(l));
      chk({tag, ".grade"}, 32'(bus.out_grade), 32'(g));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.lane_req = '0;
    step();
    rst = 1'b0;
  endtask

  logic [1:0] rr_lane  [4];
  logic [1:0] rr_grade [4];
  logic [1:0] exp_combo;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.lane_req   = '0;
    bus.lane_grade = '0;
    bus.out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.lane", 32'(bus.out_lane), 32'd0);
    chk("rst.grade", 32'(bus.out_grade), 32'd0);
    chk("rst.combo", 32'(bus.combo), 32'd0);
    chk("rst.overrun", 32'(bus.overrun), 32'd0);

    // Single request: lane 1 grade 11
    bus.out_ready  = 1'b1;
    bus.lane_req   = 4'b0010;
    bus.lane_grade = 8'b00_00_11_00;
    step();
    bus.lane_req = '0;
    chk_out("single.e1", 1'b0, 2'd0, 2'd0);
    step();
    chk_out("single.e2", 1'b1, 2'd1, 2'd3);
    step();
    chk_out("single.e3", 1'b0, 2'd0, 2'd0);

    // Round-robin: two 1111 bursts, each served 0..3
    do_reset();
    rr_lane  = '{2'd0, 2'd1, 2'd2, 2'd3};
    rr_grade = '{2'd3, 2'd2, 2'd1, 2'd3};
    bus.out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.lane_req   = 4'b1111;
      bus.lane_grade = 8'b11_01_10_11;
      step();
      bus.lane_req = '0;
      chk_out("rr.idle", 1'b0, 2'd0, 2'd0);
      for (int n = 0; n < 4; n++) begin
        step();
        chk_out($sformatf("rr.b%0d.n%0d", b, n), 1'b1, rr_lane[n], rr_grade[n]);
        exp_combo = (b == 0) ? 2'(n) : 2'd3;
        chk($sformatf("rr.combo.b%0d.n%0d", b, n), 32'(bus.combo),
            ComboEn ? 32'(exp_combo) : 32'd0);
      end
      step();
      chk_out("rr.drain", 1'b0, 2'd0, 2'd0);
      chk("rr.combo.sat", 32'(bus.combo), ComboEn ? 32'd3 : 32'd0);
    end

    // Miss event on lane 0 clears the combo once transferred
    bus.lane_req   = 4'b0001;
    bus.lane_grade = 8'b00_00_00_00;
    step();
    bus.lane_req = '0;
    step();
    chk_out("miss.out", 1'b1, 2'd0, 2'd0);
    chk("miss.combo.before", 32'(bus.combo), ComboEn ? 32'd3 : 32'd0);
    step();
    chk_out("miss.drain", 1'b0, 2'd0, 2'd0);
    chk("miss.combo.after", 32'(bus.combo), 32'd0);

    // Backpressure: lanes 0 and 2 pending, out_ready low for 5 cycles
    do_reset();
    bus.out_ready  = 1'b0;
    bus.lane_req   = 4'b0101;
    bus.lane_grade = 8'b00_01_00_10;
    step();
    bus.lane_req = '0;
    step();
    chk_out("bp.load", 1'b1, 2'd0, 2'd2);
    for (int n = 0; n < 5; n++) begin
      step();
      chk_out($sformatf("bp.hold%0d", n), 1'b1, 2'd0, 2'd2);
    end
    bus.out_ready = 1'b1;
    step();
    chk_out("bp.lane2", 1'b1, 2'd2, 2'd1);
    step();
    chk_out("bp.drain", 1'b0, 2'd0, 2'd0);

    // Overrun: output stalled on lane 0, lane 3 overwritten 01 -> 11
    do_reset();
    bus.out_ready  = 1'b0;
    bus.lane_req   = 4'b0001;
    bus.lane_grade = 8'b00_00_00_10;
    step();
    bus.lane_req = '0;
    step();
    chk_out("ovr.stall", 1'b1, 2'd0, 2'd2);
    bus.lane_req   = 4'b1000;
    bus.lane_grade = 8'b01_00_00_00;
    step();
    bus.lane_req = '0;
    chk("ovr.first", 32'(bus.overrun), 32'd0);
    step();
    bus.lane_req   = 4'b1000;
    bus.lane_grade = 8'b11_00_00_00;
    step();
    bus.lane_req = '0;
    chk("ovr.set", 32'(bus.overrun), 32'd1);
    chk_out("ovr.still", 1'b1, 2'd0, 2'd2);
    bus.out_ready = 1'b1;
    step();
    chk_out("ovr.lane3", 1'b1, 2'd3, 2'd3);
    step();
    chk_out("ovr.drain", 1'b0, 2'd0, 2'd0);
    step();
    chk_out("ovr.once", 1'b0, 2'd0, 2'd0);
    chk("ovr.sticky", 32'(bus.overrun), 32'd1);

    // Set beats clear on lane 0
    do_reset();
    chk("sbc.rst.overrun", 32'(bus.overrun), 32'd0);
    bus.out_ready  = 1'b1;
    bus.lane_req   = 4'b0001;
    bus.lane_grade = 8'b00_00_00_11;
    step();
    bus.lane_req   = 4'b0001;
    bus.lane_grade = 8'b00_00_00_10;
    step();
    bus.lane_req = '0;
    chk_out("sbc.old", 1'b1, 2'd0, 2'd3);
    step();
    chk_out("sbc.new", 1'b1, 2'd0, 2'd2);
    step();
    chk_out("sbc.drain", 1'b0, 2'd0, 2'd0);
    chk("sbc.overrun", 32'(bus.overrun), 32'd0);

    // Reset mid-burst, with requests during the reset cycle ignored
    do_reset();
    bus.out_ready  = 1'b1;
    bus.lane_req   = 4'b1111;
    bus.lane_grade = 8'b11_01_10_11;
    step();
    bus.lane_req = '0;
    step();
    step();
    chk_out("mid.pre", 1'b1, 2'd1, 2'd2);
    chk("mid.combo.pre", 32'(bus.combo), ComboEn ? 32'd1 : 32'd0);
    rst = 1'b1;
    bus.lane_req = 4'b1111;
    step();
    rst = 1'b0;
    bus.lane_req = '0;
    chk("mid.valid", 32'(bus.out_valid), 32'd0);
    chk("mid.lane", 32'(bus.out_lane), 32'd0);
    chk("mid.grade", 32'(bus.out_grade), 32'd0);
    chk("mid.combo", 32'(bus.combo), 32'd0);
    chk("mid.overrun", 32'(bus.overrun), 32'd0);
    step();
    chk("mid.stale1", 32'(bus.out_valid), 32'd0);
    step();
    chk("mid.stale2", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
